// File: rtl/linear_layer_sequencer.sv
// linear_layer_sequencer: streams feature/weight chunks into an external vector multiplier,
// accumulates one dot product per neuron and emits each neuron result on a ready/valid stream.
module linear_layer_sequencer #(
  parameter int PRECISION = 8,
  parameter int NUM_FEATURES = 4,
  parameter int NUM_CHUNKS = 4,
  parameter int NUM_NEURONS = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(NUM_CHUNKS)-1:0]         feat_addr,
  input  logic [NUM_FEATURES*PRECISION-1:0]     feat_data,
  output logic [$clog2(NUM_NEURONS*NUM_CHUNKS)-1:0] wgt_addr,
  input  logic [NUM_FEATURES*PRECISION-1:0]     wgt_data,
  output logic                                  mul_ce,
  output logic [NUM_FEATURES*PRECISION-1:0]     mul_features,
  output logic [NUM_FEATURES*PRECISION-1:0]     mul_weights,
  input  logic [31:0]                           mul_acc,
  input  logic [31:0]                           mul_ai,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [31:0]                           out_data,
  output logic [31:0]                           out_ai,
  output logic [$clog2(NUM_NEURONS)-1:0]        out_idx
);
  localparam int CW = $clog2(NUM_CHUNKS);
  localparam int NW = $clog2(NUM_NEURONS);
  localparam int AW = $clog2(NUM_NEURONS*NUM_CHUNKS);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
  state_t state;
  logic [CW-1:0] c;
  logic [NW-1:0] n;
  logic d, acc_en;
  logic [31:0] acc, ai;
  logic rd;
  assign rd = state == RUN;
  assign feat_addr = rd ? c : '0;
  assign wgt_addr = rd ? AW'(n * NUM_CHUNKS + c) : '0;
  assign mul_features = mul_ce ? feat_data : '0;
  assign mul_weights = mul_ce ? wgt_data : '0;
  assign busy = state != IDLE;
  assign out_valid = state == OUT;
  assign out_data = out_valid ? acc : '0;
  assign out_ai = out_valid ? ai : '0;
  assign out_idx = out_valid ? n : '0;
  // acc_en trails mul_ce by one cycle, matching the multiplier's registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c <= '0;
      n <= '0;
      d <= 1'b0;
      acc_en <= 1'b0;
      mul_ce <= 1'b0;
      done <= 1'b0;
      acc <= '0;
      ai <= '0;
    end else begin
      mul_ce <= rd;
      acc_en <= mul_ce;
      done <= 1'b0;
      if (acc_en) begin
        acc <= acc + mul_acc;
        ai <= ai + mul_ai;
      end
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          n <= '0;
          c <= '0;
          acc <= '0;
          ai <= '0;
        end
        RUN: begin
          c <= c == CW'(NUM_CHUNKS - 1) ? '0 : c + 1'b1;
          if (c == CW'(NUM_CHUNKS - 1)) state <= DRAIN;
        end
        DRAIN: begin
          d <= ~d;
          if (d) state <= OUT;
        end
        OUT: if (out_ready) begin
          if (n == NW'(NUM_NEURONS - 1)) begin
            state <= IDLE;
            n <= '0;
            done <= 1'b1;
          end else begin
            state <= RUN;
            n <= n + 1'b1;
            c <= '0;
            acc <= '0;
            ai <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_linear_layer_sequencer.sv
// tb_linear_layer_sequencer: memory and multiplier models around the sequencer, checked
// against per-neuron dot products computed directly from the memory contents.
module tb_linear_layer_sequencer;
  localparam int P = 8, NF = 4, NC = 4, NN = 8, DW = NF * P;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 0;
  logic busy, done, mul_ce, out_valid;
  logic [1:0] feat_addr;
  logic [4:0] wgt_addr;
  logic [2:0] out_idx;
  logic [DW-1:0] feat_data, wgt_data, mul_features, mul_weights;
  logic [31:0] mul_acc, mul_ai, out_data, out_ai;
  logic [DW-1:0] fmem[NC];
  logic [DW-1:0] wmem[NN*NC];
  bit force_wrap = 0;
  logic [31:0] exp_data[NN], exp_ai[NN], got_data[NN], got_ai[NN];
  int checks = 0, failures = 0, nres, ndone, nce;
  typedef struct {int idx; logic [31:0] data; logic [31:0] ai;} vec_t;
  vec_t tbl[NN];

  linear_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .feat_addr(feat_addr), .feat_data(feat_data), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .mul_ce(mul_ce), .mul_features(mul_features), .mul_weights(mul_weights),
    .mul_acc(mul_acc), .mul_ai(mul_ai), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ai(out_ai), .out_idx(out_idx));

  always #5 clk = ~clk;

  function automatic logic [31:0] dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [31:0] s = 0;
    for (int f = 0; f < NF; f++) s += 32'(a[f*P+:P]) * 32'(b[f*P+:P]);
    return s;
  endfunction

  function automatic logic [31:0] lsum(input logic [DW-1:0] a);
    logic [31:0] s = 0;
    for (int f = 0; f < NF; f++) s += 32'(a[f*P+:P]);
    return s;
  endfunction

  // synchronous-read memories and a registered multiplier; garbage when not enabled
  always @(posedge clk) begin
    feat_data <= fmem[feat_addr];
    wgt_data <= wmem[wgt_addr];
    mul_acc <= mul_ce ? (force_wrap ? 32'hFFFF_FFFF : dot(mul_features, mul_weights)) : 32'hDEAD_BEEF;
    mul_ai <= mul_ce ? lsum(mul_features) : 32'h0BAD_F00D;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_model();
    logic [31:0] a = 0;
    for (int c = 0; c < NC; c++) a += lsum(fmem[c]);
    for (int n = 0; n < NN; n++) begin
      logic [31:0] s = 0;
      for (int c = 0; c < NC; c++) s += force_wrap ? 32'hFFFF_FFFF : dot(fmem[c], wmem[n*NC+c]);
      exp_data[n] = s;
      exp_ai[n] = a;
    end
  endtask

  task automatic fill_basic();
    for (int c = 0; c < NC; c++) fmem[c] = {NF{8'd1}};
    for (int n = 0; n < NN; n++) for (int c = 0; c < NC; c++) wmem[n*NC+c] = {NF{8'(n + 1)}};
  endtask

  task automatic fill_random();
    for (int c = 0; c < NC; c++) fmem[c] = $urandom;
    for (int i = 0; i < NN * NC; i++) wmem[i] = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    for (int n = 0; n < NN; n++) begin
      chk({tag, "_data"}, got_data[n], exp_data[n]);
      chk({tag, "_ai"}, got_ai[n], exp_ai[n]);
    end
  endtask

  // called at posedge+1 with the sequencer idle; runs one full layer
  task automatic run_layer(input bit rnd_ready, input int stall_n, input bit restart);
    int cyc = 0, stall = 0;
    bit pv = 0, fin = 0;
    logic [31:0] pd = 0, pa = 0;
    logic [2:0] pi = 0;
    nres = 0; ndone = 0; nce = 0;
    start = 1;
    out_ready = 0;
    tick();
    start = 0;
    chk("busy_after_start", busy, 1);
    while (!fin && cyc < 3000) begin
      cyc++;
      start = restart && cyc == 3;
      if (mul_ce) nce++;
      if (done) begin
        ndone++;
        chk("busy_at_done", busy, 0);
        fin = 1;
      end
      if (pv && !out_valid) chk("valid_held", out_valid, 1);
      if (out_valid) begin
        if (pv) begin
          chk("hold_data", out_data, pd);
          chk("hold_ai", out_ai, pa);
          chk("hold_idx", out_idx, pi);
        end else if (nres < NN) begin
          chk("idx_order", out_idx, nres);
          got_data[nres] = out_data;
          got_ai[nres] = out_ai;
        end else chk("extra_result", nres, NN - 1);
        if (int'(out_idx) == stall_n && stall < 5) begin
          stall++;
          out_ready = 0;
          chk("stall_no_ce", mul_ce, 0);
          chk("stall_feat_addr", feat_addr, 0);
          chk("stall_wgt_addr", wgt_addr, 0);
        end else out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        pv = !out_ready;
        pd = out_data; pa = out_ai; pi = out_idx;
        if (out_ready) nres++;
      end else begin
        pv = 0;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick();
    end
    start = 0;
    out_ready = 0;
    chk("done_seen", fin, 1);
    chk("result_count", nres, NN);
    chk("done_count", ndone, 1);
    chk("mul_ce_count", nce, NN * NC);
    if (stall_n >= 0) chk("stall_cycles", stall, 5);
    chk("done_single_pulse", done, 0);
    chk("busy_low_after", busy, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mul_ce"}, mul_ce, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_feat_addr"}, feat_addr, 0);
    chk({tag, "_wgt_addr"}, wgt_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_ai"}, out_ai, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_mul_features"}, mul_features, 0);
    chk({tag, "_mul_weights"}, mul_weights, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < NN; n++) tbl[n] = '{n, 32'(16 * (n + 1)), 32'd16};
    fill_basic();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;
    tick();
    chk("idle_without_start", busy, 0);
    // latency: start high during cycle 0
    start = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      start = 0;
      chk("lat_feat_addr", feat_addr, k <= 4 ? k - 1 : 0);
      chk("lat_wgt_addr", wgt_addr, k <= 4 ? k - 1 : 0);
      chk("lat_mul_ce", mul_ce, k >= 2 && k <= 5);
      chk("lat_out_valid", out_valid, k >= 7);
      chk("lat_busy", busy, 1);
    end
    #2 rst_n = 0;
    #1 check_zero("reset_in_out");
    tick();
    rst_n = 1;
    tick();
    // basic table-driven check
    run_layer(0, -1, 0);
    for (int i = 0; i < NN; i++) begin
      chk("basic_data", got_data[tbl[i].idx], tbl[i].data);
      chk("basic_ai", got_ai[tbl[i].idx], tbl[i].ai);
    end
    // backpressure on neuron 3
    build_model();
    run_layer(0, 3, 0);
    compare_model("bp");
    // wraparound accumulation
    for (int c = 0; c < NC; c++) fmem[c] = '1;
    for (int i = 0; i < NN * NC; i++) wmem[i] = '1;
    force_wrap = 1;
    run_layer(0, -1, 0);
    for (int n = 0; n < NN; n++) begin
      chk("wrap_data", got_data[n], 32'hFFFF_FFFC);
      chk("wrap_ai", got_ai[n], 32'd4080);
    end
    force_wrap = 0;
    // second start while busy
    fill_basic();
    run_layer(0, -1, 1);
    for (int i = 0; i < NN; i++) chk("restart_data", got_data[tbl[i].idx], tbl[i].data);
    // randomized layers with random backpressure
    for (int t = 0; t < 4; t++) begin
      fill_random();
      build_model();
      run_layer(1, t == 0 ? 5 : -1, 0);
      compare_model("rand");
    end
    // reset during neuron 2 RUN
    fill_random();
    build_model();
    start = 1;
    out_ready = 1;
    tick();
    start = 0;
    for (int i = 0; i < 200 && !(out_valid && out_idx == 1); i++) tick();
    chk("reached_n1", out_valid && out_idx == 1, 1);
    tick();
    tick();
    chk("wgt_addr_n2_c1", wgt_addr, 9);
    out_ready = 0;
    #2 rst_n = 0;
    #1 check_zero("reset_mid_run");
    tick();
    rst_n = 1;
    tick();
    tick();
    chk("idle_after_reset", busy, 0);
    chk("no_ce_after_reset", mul_ce, 0);
    run_layer(0, -1, 0);
    compare_model("post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
